hazard_control_unit: RTL and testbench



---
 rtl/hazard_control_unit.sv | 261 ++++++++++++++++++++++++++
 tb/tb_hazard_control_unit.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
// ---------------------------------------------------------------------------
// hazard_control_unit
//
// Hazard detection and branch resolution unit for a 5-stage MIPS pipeline.
// It sits beside the ID stage and has four jobs:
//   * detect load-use hazards and branch-operand hazards, and stall on them
//   * forward EX/MEM results into the ID-stage branch comparator
//   * resolve BEQ / BNE / J / JR in ID, producing the next PC and an IF/ID flush
//   * run a halt-drain FSM (RUN -> DRAIN -> HALTED) so that in-flight
//     instructions retire before the core freezes
//
// Optional feature (compile-time macro HAZARD_STATS_EN):
//   defined     : saturating counters o_stall_cycles / o_flush_count
//   not defined : both statistics outputs are tied to zero, with no counter flops
//
// Ports
//   i_clk, i_reset          clock (rising edge), synchronous active-high reset
//   i_valid_id              ID holds a valid instruction
//   i_branch_type           000 none, 001 BEQ, 010 BNE, 011 J, 100 JR
//   i_halt_instr            ID instruction is HALT
//   i_rs, i_rt              ID source registers
//   i_rs_data, i_rt_data    register-file read data (WB bypass already applied)
//   i_ex_*                  EX destination register, control bits, ALU result
//   i_mem_*                 MEM destination register, control bits, ALU result
//   i_jump_target           BEQ/BNE/J target computed in ID
//   i_pc_plus4              sequential next PC
//   o_stall                 hold PC and IF/ID, inject a bubble into ID/EX
//   o_flush                 clear IF/ID (taken branch or jump)
//   o_next_pc               next PC value
//   o_halted                core frozen after drain
//   o_stall_cycles          hazard stall cycles seen in RUN (saturating)
//   o_flush_count           flush cycles (saturating)
// ---------------------------------------------------------------------------
module hazard_control_unit #(
    parameter int N_BITS        = 32,
    parameter int N_BITS_REG    = 5,
    parameter int EX_BRANCH_FWD = 1,
    parameter int DRAIN_CYCLES  = 3,
    parameter int STAT_BITS     = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_valid_id,
    input  logic [2:0]            i_branch_type,
    input  logic                  i_halt_instr,
    input  logic [N_BITS_REG-1:0] i_rs,
    input  logic [N_BITS_REG-1:0] i_rt,
    input  logic [N_BITS-1:0]     i_rs_data,
    input  logic [N_BITS-1:0]     i_rt_data,
    input  logic [N_BITS_REG-1:0] i_ex_rd,
    input  logic                  i_ex_reg_write,
    input  logic                  i_ex_mem_read,
    input  logic [N_BITS-1:0]     i_ex_alu_result,
    input  logic [N_BITS_REG-1:0] i_mem_rd,
    input  logic                  i_mem_reg_write,
    input  logic                  i_mem_mem_read,
    input  logic [N_BITS-1:0]     i_mem_alu_result,
    input  logic [N_BITS-1:0]     i_jump_target,
    input  logic [N_BITS-1:0]     i_pc_plus4,
    output logic                  o_stall,
    output logic                  o_flush,
    output logic [N_BITS-1:0]     o_next_pc,
    output logic                  o_halted,
    output logic [STAT_BITS-1:0]  o_stall_cycles,
    output logic [STAT_BITS-1:0]  o_flush_count
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam logic [2:0] BR_BEQ = 3'b001;
    localparam logic [2:0] BR_BNE = 3'b010;
    localparam logic [2:0] BR_J   = 3'b011;
    localparam logic [2:0] BR_JR  = 3'b100;

    localparam bit EX_FWD = (EX_BRANCH_FWD != 0);

    // The drain counter is 4 bits wide; out-of-range settings are clamped
    // so the FSM always reaches HALTED.
    localparam int DRAIN_CLAMP = (DRAIN_CYCLES < 1)  ? 1  :
                                 (DRAIN_CYCLES > 15) ? 15 : DRAIN_CYCLES;
    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CLAMP);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [3:0] drain_cnt_reg, drain_cnt_next;

    // -----------------------------------------------------------------------
    // Branch decode. Unused encodings decode as "no branch".
    // -----------------------------------------------------------------------
    logic is_beq, is_bne, is_j, is_jr;

    assign is_beq = (i_branch_type == BR_BEQ);
    assign is_bne = (i_branch_type == BR_BNE);
    assign is_j   = (i_branch_type == BR_J);
    assign is_jr  = (i_branch_type == BR_JR);

    // -----------------------------------------------------------------------
    // Per-operand match, forwarding and hazard terms. Operand 0 is rs and
    // operand 1 is rt. JR only reads rs, so only rs can stall a JR.
    // -----------------------------------------------------------------------
    logic [N_BITS_REG-1:0] src_reg  [2];
    logic [N_BITS-1:0]     reg_data [2];
    logic [N_BITS-1:0]     fwd_data [2];
    logic [1:0]            ex_hit;
    logic [1:0]            mem_hit;
    logic [1:0]            br_reads;
    logic [1:0]            load_use;
    logic [1:0]            br_wait;

    assign src_reg[0]  = i_rs;
    assign src_reg[1]  = i_rt;
    assign reg_data[0] = i_rs_data;
    assign reg_data[1] = i_rt_data;
    assign br_reads[0] = is_beq | is_bne | is_jr;
    assign br_reads[1] = is_beq | is_bne;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            // $0 is hard-wired to zero and never aliases a pipeline result.
            assign ex_hit[gi]  = (src_reg[gi] != '0) && (src_reg[gi] == i_ex_rd);
            assign mem_hit[gi] = (src_reg[gi] != '0) && (src_reg[gi] == i_mem_rd);

            // EX is the younger producer, so it wins over MEM. Loaded data
            // is not available in EX or MEM, so those stages never forward it.
            assign fwd_data[gi] =
                (EX_FWD && ex_hit[gi] && i_ex_reg_write && !i_ex_mem_read) ? i_ex_alu_result  :
                (mem_hit[gi] && i_mem_reg_write && !i_mem_mem_read)        ? i_mem_alu_result :
                                                                             reg_data[gi];

            assign load_use[gi] = i_ex_mem_read && ex_hit[gi];

            // A branch on a load waits in EX (load-use) and again in MEM,
            // which gives the two stall cycles before the WB bypass can
            // supply the data.
            assign br_wait[gi] = br_reads[gi] &&
                                 ((ex_hit[gi] && i_ex_reg_write && !EX_FWD) ||
                                  (mem_hit[gi] && i_mem_mem_read));
        end
    endgenerate

    logic haz;
    assign haz = i_valid_id && ((|load_use) || (|br_wait));

    // -----------------------------------------------------------------------
    // Branch resolution in ID.
    // -----------------------------------------------------------------------
    logic run;
    logic resolve;
    logic operands_eq;
    logic taken;
    logic [N_BITS-1:0] target;

    assign run         = (state_reg == ST_RUN);
    assign resolve     = run && i_valid_id && !haz;
    assign operands_eq = (fwd_data[0] == fwd_data[1]);
    assign taken       = resolve && ((is_beq && operands_eq) ||
                                     (is_bne && !operands_eq) ||
                                     is_j || is_jr);
    assign target      = is_jr ? fwd_data[0] : i_jump_target;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg     <= ST_RUN;
            drain_cnt_reg <= 4'd0;
        end else begin
            state_reg     <= state_next;
            drain_cnt_reg <= drain_cnt_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        drain_cnt_next = drain_cnt_reg;
        case (state_reg)
            ST_RUN: begin
                // A HALT blocked by a hazard simply waits in ID.
                if (i_valid_id && i_halt_instr && !haz) begin
                    state_next     = ST_DRAIN;
                    drain_cnt_next = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_reg <= 4'd1) begin
                    state_next     = ST_HALTED;
                    drain_cnt_next = 4'd0;
                end else begin
                    drain_cnt_next = drain_cnt_reg - 4'd1;
                end
            end
            ST_HALTED: begin
                state_next = ST_HALTED;
            end
            default: begin
                state_next     = ST_RUN;
                drain_cnt_next = 4'd0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: output logic. Reset forces the idle pipeline-control values even
    // before the state register has been cleared.
    // -----------------------------------------------------------------------
    always_comb begin
        o_stall   = 1'b0;
        o_flush   = 1'b0;
        o_next_pc = i_pc_plus4;
        o_halted  = 1'b0;
        if (!i_reset) begin
            o_stall  = !run || haz;
            // taken already implies RUN and no hazard, so a flush never
            // coincides with a stall.
            o_flush  = taken;
            o_halted = (state_reg == ST_HALTED);
            if (taken) begin
                o_next_pc = target;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Statistics
    // -----------------------------------------------------------------------
`ifdef HAZARD_STATS_EN
    logic [STAT_BITS-1:0] stall_cycles_reg;
    logic [STAT_BITS-1:0] flush_count_reg;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stall_cycles_reg <= '0;
            flush_count_reg  <= '0;
        end else begin
            if (run && haz && (stall_cycles_reg != '1)) begin
                stall_cycles_reg <= stall_cycles_reg + 1'b1;
            end
            if (o_flush && (flush_count_reg != '1)) begin
                flush_count_reg <= flush_count_reg + 1'b1;
            end
        end
    end

    assign o_stall_cycles = stall_cycles_reg;
    assign o_flush_count  = flush_count_reg;
`else
    assign o_stall_cycles = '0;
    assign o_flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_control_unit
//
// Scoreboard bench for hazard_control_unit. Two instances share every input:
// dut_f forwards EX results into the comparator (EX_BRANCH_FWD=1) and dut_s
// stalls instead (EX_BRANCH_FWD=0). Each stimulus cycle pushes the
// hand-computed expected outputs of both instances; a monitor pops and
// compares them on the falling edge of the same cycle.
// Build with +define+HAZARD_STATS_EN to exercise the statistics counters.
// ---------------------------------------------------------------------------
module tb_hazard_control_unit;

    localparam logic [31:0] PC4 = 32'h0000_1004;
    localparam logic [31:0] TGT = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_id;
    logic [2:0]  branch_type;
    logic        halt_instr;
    logic [4:0]  rs, rt;
    logic [31:0] rs_data, rt_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read;
    logic [31:0] ex_alu_result;
    logic [4:0]  mem_rd;
    logic        mem_reg_write, mem_mem_read;
    logic [31:0] mem_alu_result;
    logic [31:0] jump_target;
    logic [31:0] pc_plus4;

    logic        stall_f, flush_f, halted_f;
    logic [31:0] next_pc_f;
    logic [15:0] stall_cycles_f, flush_count_f;
    logic        stall_s, flush_s, halted_s;
    logic [31:0] next_pc_s;
    logic [15:0] stall_cycles_s, flush_count_s;

    always #5 clk = ~clk;

    hazard_control_unit #(.EX_BRANCH_FWD(1)) dut_f (
        .i_clk(clk), .i_reset(reset), .i_valid_id(valid_id),
        .i_branch_type(branch_type), .i_halt_instr(halt_instr),
        .i_rs(rs), .i_rt(rt), .i_rs_data(rs_data), .i_rt_data(rt_data),
        .i_ex_rd(ex_rd), .i_ex_reg_write(ex_reg_write), .i_ex_mem_read(ex_mem_read),
        .i_ex_alu_result(ex_alu_result), .i_mem_rd(mem_rd),
        .i_mem_reg_write(mem_reg_write), .i_mem_mem_read(mem_mem_read),
        .i_mem_alu_result(mem_alu_result), .i_jump_target(jump_target),
        .i_pc_plus4(pc_plus4), .o_stall(stall_f), .o_flush(flush_f),
        .o_next_pc(next_pc_f), .o_halted(halted_f),
        .o_stall_cycles(stall_cycles_f), .o_flush_count(flush_count_f)
    );

    hazard_control_unit #(.EX_BRANCH_FWD(0)) dut_s (
        .i_clk(clk), .i_reset(reset), .i_valid_id(valid_id),
        .i_branch_type(branch_type), .i_halt_instr(halt_instr),
        .i_rs(rs), .i_rt(rt), .i_rs_data(rs_data), .i_rt_data(rt_data),
        .i_ex_rd(ex_rd), .i_ex_reg_write(ex_reg_write), .i_ex_mem_read(ex_mem_read),
        .i_ex_alu_result(ex_alu_result), .i_mem_rd(mem_rd),
        .i_mem_reg_write(mem_reg_write), .i_mem_mem_read(mem_mem_read),
        .i_mem_alu_result(mem_alu_result), .i_jump_target(jump_target),
        .i_pc_plus4(pc_plus4), .o_stall(stall_s), .o_flush(flush_s),
        .o_next_pc(next_pc_s), .o_halted(halted_s),
        .o_stall_cycles(stall_cycles_s), .o_flush_count(flush_count_s)
    );

    // Expected word layout: {stall, flush, halted, next_pc}
    typedef struct {
        string       name;
        logic [34:0] w_f;
        logic [34:0] w_s;
        bit          chk;
        bit          quiet;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    bit          chk_next   = 0;
    logic [15:0] sc_next    = '0;
    logic [15:0] fc_next    = '0;
    bit          quiet_mode = 0;

    task automatic expect2(input string nm,
                           input logic s0, input logic f0, input logic h0, input logic [31:0] p0,
                           input logic s1, input logic f1, input logic h1, input logic [31:0] p1);
        exp_t e;
        e.name  = nm;
        e.w_f   = {s0, f0, h0, p0};
        e.w_s   = {s1, f1, h1, p1};
        e.chk   = chk_next;
        e.sc    = sc_next;
        e.fc    = fc_next;
        e.quiet = quiet_mode;
        chk_next = 0;
        sb.push_back(e);
    endtask

    task automatic expect1(input string nm, input logic s, input logic f,
                           input logic h, input logic [31:0] p);
        expect2(nm, s, f, h, p, s, f, h, p);
    endtask

    task automatic stats_at(input logic [15:0] sc, input logic [15:0] fc);
        chk_next = 1;
        sc_next  = sc;
        fc_next  = fc;
    endtask

    task automatic clr();
        reset = 0; valid_id = 0; branch_type = 3'b000; halt_instr = 0;
        rs = 0; rt = 0; rs_data = 0; rt_data = 0;
        ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0; ex_alu_result = 0;
        mem_rd = 0; mem_reg_write = 0; mem_mem_read = 0; mem_alu_result = 0;
        jump_target = TGT; pc_plus4 = PC4;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clr();
    endtask

    // Monitor: compare at the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [34:0] a_f, a_s;
            e   = sb.pop_front();
            a_f = {stall_f, flush_f, halted_f, next_pc_f};
            a_s = {stall_s, flush_s, halted_s, next_pc_s};
            checks++;
            if (a_f !== e.w_f) begin
                failures++;
                $display("FAIL %s fwd1: got stall=%b flush=%b halted=%b pc=%h, want stall=%b flush=%b halted=%b pc=%h",
                         e.name, a_f[34], a_f[33], a_f[32], a_f[31:0],
                         e.w_f[34], e.w_f[33], e.w_f[32], e.w_f[31:0]);
            end
            checks++;
            if (a_s !== e.w_s) begin
                failures++;
                $display("FAIL %s fwd0: got stall=%b flush=%b halted=%b pc=%h, want stall=%b flush=%b halted=%b pc=%h",
                         e.name, a_s[34], a_s[33], a_s[32], a_s[31:0],
                         e.w_s[34], e.w_s[33], e.w_s[32], e.w_s[31:0]);
            end
`ifdef HAZARD_STATS_EN
            if (e.chk) begin
                checks++;
                if ({stall_cycles_f, flush_count_f, stall_cycles_s, flush_count_s} !==
                    {e.sc, e.fc, e.sc, e.fc}) begin
                    failures++;
                    $display("FAIL %s stats: got f=%h/%h s=%h/%h, want %h/%h",
                             e.name, stall_cycles_f, flush_count_f,
                             stall_cycles_s, flush_count_s, e.sc, e.fc);
                end
            end
`else
            checks++;
            if ({stall_cycles_f, flush_count_f, stall_cycles_s, flush_count_s} !== 64'd0) begin
                failures++;
                $display("FAIL %s stats_tied: got f=%h/%h s=%h/%h, want 0",
                         e.name, stall_cycles_f, flush_count_f, stall_cycles_s, flush_count_s);
            end
`endif
            if (!e.quiet) begin
                $display("txn %s fwd1=%b%b%b/%h fwd0=%b%b%b/%h", e.name,
                         a_f[34], a_f[33], a_f[32], a_f[31:0],
                         a_s[34], a_s[33], a_s[32], a_s[31:0]);
            end
        end
    end

    initial begin
        int sat_len;
        clr();
        reset = 1;

        // Reset forces idle outputs even with a hazard, J and HALT present.
        repeat (2) begin
            step(); reset = 1; valid_id = 1; halt_instr = 1; branch_type = 3'b011;
            ex_rd = 5; ex_mem_read = 1; ex_reg_write = 1; rs = 5;
            expect1("reset", 0, 0, 0, PC4);
        end

        step(); expect1("idle", 0, 0, 0, PC4);

        // Load to $5 in EX, add reads $5: one stall, then clear.
        step(); valid_id = 1; rs = 5; rt = 6;
        ex_rd = 5; ex_reg_write = 1; ex_mem_read = 1;
        expect1("load_use", 1, 0, 0, PC4);
        step(); valid_id = 1; rs = 5; rt = 6;
        mem_rd = 5; mem_reg_write = 1; mem_mem_read = 1;
        stats_at(16'd1, 16'd0);
        expect1("load_use_next", 0, 0, 0, PC4);

        // BEQ $2,$3 on a load to $2: stalls in EX and MEM, then taken (7==7).
        step(); valid_id = 1; branch_type = 3'b001; rs = 2; rt = 3;
        ex_rd = 2; ex_reg_write = 1; ex_mem_read = 1;
        expect1("beq_ld_ex", 1, 0, 0, PC4);
        step(); valid_id = 1; branch_type = 3'b001; rs = 2; rt = 3;
        mem_rd = 2; mem_reg_write = 1; mem_mem_read = 1;
        expect1("beq_ld_mem", 1, 0, 0, PC4);
        step(); valid_id = 1; branch_type = 3'b001; rs = 2; rt = 3;
        rs_data = 7; rt_data = 7;
        expect1("beq_taken", 0, 1, 0, TGT);

        // BNE $4,$0 with EX writing 9 to $4: forwarded and taken, or one stall.
        step(); valid_id = 1; branch_type = 3'b010; rs = 4; rt = 0;
        ex_rd = 4; ex_reg_write = 1; ex_alu_result = 32'd9;
        stats_at(16'd3, 16'd1);
        expect2("bne_ex", 0, 1, 0, TGT, 1, 0, 0, PC4);
        step(); valid_id = 1; branch_type = 3'b010; rs = 4; rt = 0;
        mem_rd = 4; mem_reg_write = 1; mem_alu_result = 32'd9;
        expect1("bne_mem", 0, 1, 0, TGT);

        step(); valid_id = 1; branch_type = 3'b010; rs = 2; rt = 3;
        rs_data = 5; rt_data = 5;
        expect1("bne_not_taken", 0, 0, 0, PC4);
        step(); valid_id = 1; branch_type = 3'b001; rs = 2; rt = 3;
        rs_data = 5; rt_data = 6;
        expect1("beq_not_taken", 0, 0, 0, PC4);

        // JR $31 from MEM forwarding; then EX has priority over MEM.
        step(); valid_id = 1; branch_type = 3'b100; rs = 31; rs_data = 32'hdead;
        mem_rd = 31; mem_reg_write = 1; mem_alu_result = 32'h100;
        expect1("jr_mem", 0, 1, 0, 32'h100);
        step(); valid_id = 1; branch_type = 3'b100; rs = 31; rs_data = 32'hdead;
        mem_rd = 31; mem_reg_write = 1; mem_alu_result = 32'h100;
        ex_rd = 31; ex_reg_write = 1; ex_alu_result = 32'h200;
        expect2("jr_ex_prio", 0, 1, 0, 32'h200, 1, 0, 0, PC4);

        // Register 0 never hazards or forwards.
        step(); valid_id = 1; rs = 0; rt = 0; ex_rd = 0; ex_mem_read = 1; ex_reg_write = 1;
        expect1("reg0_load", 0, 0, 0, PC4);
        step(); valid_id = 1; branch_type = 3'b001; rs = 0; rt = 3;
        ex_rd = 0; ex_reg_write = 1; ex_alu_result = 32'd5;
        expect1("reg0_fwd", 0, 1, 0, TGT);

        step(); valid_id = 1; branch_type = 3'b011;
        expect1("jump", 0, 1, 0, TGT);
        step(); valid_id = 1; branch_type = 3'b101;
        expect1("bad_type", 0, 0, 0, PC4);
        step(); valid_id = 0; branch_type = 3'b011; rs = 5;
        ex_rd = 5; ex_mem_read = 1; ex_reg_write = 1;
        expect1("invalid_id", 0, 0, 0, PC4);

        // HALT blocked by a hazard, then accepted and drained.
        step(); valid_id = 1; halt_instr = 1; rs = 5;
        ex_rd = 5; ex_mem_read = 1; ex_reg_write = 1;
        expect1("halt_blocked", 1, 0, 0, PC4);
        step(); valid_id = 1; halt_instr = 1;
        expect1("halt_accept", 0, 0, 0, PC4);
        repeat (3) begin
            step(); valid_id = 1; branch_type = 3'b011;
            expect1("drain", 1, 0, 0, PC4);
        end
        step(); valid_id = 1; branch_type = 3'b011;
        expect1("halted", 1, 0, 1, PC4);
        step(); expect1("halted_hold", 1, 0, 1, PC4);
        step(); reset = 1; valid_id = 1; branch_type = 3'b011;
        expect1("reset_halted", 0, 0, 0, PC4);
        step(); expect1("run_after_reset", 0, 0, 0, PC4);

        // Reset in the middle of DRAIN.
        step(); valid_id = 1; halt_instr = 1;
        expect1("halt_accept2", 0, 0, 0, PC4);
        step(); expect1("drain2", 1, 0, 0, PC4);
        step(); reset = 1; valid_id = 1; branch_type = 3'b011;
        expect1("reset_drain", 0, 0, 0, PC4);
        step(); valid_id = 1; branch_type = 3'b011;
        expect1("run_after_drain_reset", 0, 1, 0, TGT);

        // Saturation run: forced load-use stalls after a reset.
        step(); reset = 1;
        expect1("sat_reset", 0, 0, 0, PC4);
`ifdef HAZARD_STATS_EN
        sat_len = 65536 + 5;
`else
        sat_len = 8;
`endif
        quiet_mode = 1;
        for (int i = 0; i < sat_len; i++) begin
            step(); valid_id = 1; rs = 5;
            ex_rd = 5; ex_mem_read = 1; ex_reg_write = 1;
            expect1("sat_stall", 1, 0, 0, PC4);
        end
        quiet_mode = 0;
        step();
        stats_at(16'hFFFF, 16'h0000);
        expect1("sat_check", 0, 0, 0, PC4);

        // Let the monitor drain the scoreboard, with a bounded wait.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
